stream_arbiter: RTL

Round-robin arbiter that shares one `aggregator` between NUM_SENDERS upstream `fifo` instances. It grants one sender at a time for a locked burst of exactly FETCH_WIDTH words, so every wide word the aggregator assembles comes from a single source. The block sits between the sender FIFOs' dequeue side and the aggregator's `sender_*` port, and tags each burst with the granted source index.

---
 rtl/stream_arbiter.sv | 157 +++++++++++++++
 1 files changed

// File: rtl/stream_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : stream_arbiter
// Purpose  : Round-robin arbiter granting one sender FIFO at a time for a
//            locked burst of FETCH_WIDTH words toward a shared aggregator.
//            Define STREAM_ARBITER_FIXED_PRIO_EN for strict priority
//            (index 0 highest) instead of round-robin.
// Revision : 1.0 - initial release
// ============================================================================
module stream_arbiter #(
  parameter int NUM_SENDERS = 4,
  parameter int DATA_WIDTH  = 16,
  parameter int FETCH_WIDTH = 4,
  parameter int ID_WIDTH    = 2
) (
  input  logic                              clk,
  input  logic                              rst_n,
  input  logic [NUM_SENDERS*DATA_WIDTH-1:0] in_data,
  input  logic [NUM_SENDERS-1:0]            in_empty_n,
  output logic [NUM_SENDERS-1:0]            in_deq,
  output logic [DATA_WIDTH-1:0]             out_data,
  output logic                              out_empty_n,
  input  logic                              out_deq,
  output logic [ID_WIDTH-1:0]               out_id,
  output logic                              burst_done
);

  localparam int                  CNT_W     = (FETCH_WIDTH > 1) ? $clog2(FETCH_WIDTH) : 1;
  localparam int                  SLOTS     = 2 ** ID_WIDTH;
  localparam logic [CNT_W-1:0]    LAST_BEAT = CNT_W'(FETCH_WIDTH - 1);
  localparam logic [ID_WIDTH:0]   NUM_EXT   = (ID_WIDTH + 1)'(NUM_SENDERS);

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    BURST = 1'b1
  } state_e;

  state_e              state_q, state_d;
  logic [ID_WIDTH-1:0] grant_q, grant_d;
  logic [CNT_W-1:0]    beat_cnt_q, beat_cnt_d;
  logic [ID_WIDTH-1:0] search_start;

`ifndef STREAM_ARBITER_FIXED_PRIO_EN
  localparam logic [ID_WIDTH-1:0] LAST_ID = ID_WIDTH'(NUM_SENDERS - 1);
  logic [ID_WIDTH-1:0] rr_ptr_q, rr_ptr_d;
  logic [ID_WIDTH-1:0] grant_inc;

  // Explicit wrap so non-power-of-two sender counts return to 0.
  assign grant_inc    = (grant_q == LAST_ID) ? '0 : grant_q + 1'b1;
  assign search_start = rr_ptr_q;
`else
  assign search_start = '0;
`endif

  // Pad sender views to the full id space so grant-indexed selects are exact.
  logic [SLOTS-1:0]      ready_pad;
  logic [DATA_WIDTH-1:0] word_pad [SLOTS];

  always_comb begin
    ready_pad = '0;
    for (int i = 0; i < SLOTS; i++) begin
      word_pad[i] = '0;
    end
    for (int i = 0; i < NUM_SENDERS; i++) begin
      ready_pad[i] = in_empty_n[i];
      word_pad[i]  = in_data[i*DATA_WIDTH +: DATA_WIDTH];
    end
  end

  logic [ID_WIDTH-1:0] pick;
  logic [ID_WIDTH:0]   probe;
  logic                found;

  always_comb begin
    pick  = search_start;
    probe = '0;
    found = 1'b0;
    for (int k = 0; k < NUM_SENDERS; k++) begin
      probe = {1'b0, search_start} + (ID_WIDTH + 1)'(k);
      if (probe >= NUM_EXT) begin
        probe = probe - NUM_EXT;
      end
      if (!found && ready_pad[probe[ID_WIDTH-1:0]]) begin
        pick  = probe[ID_WIDTH-1:0];
        found = 1'b1;
      end
    end
  end

  logic beat;
  logic last_beat;

  assign out_id      = grant_q;
  assign out_data    = word_pad[grant_q];
  assign out_empty_n = (state_q == BURST) && ready_pad[grant_q];
  assign beat        = out_empty_n && out_deq;
  assign last_beat   = beat && (beat_cnt_q == LAST_BEAT);
  assign burst_done  = last_beat;

  always_comb begin
    in_deq = '0;
    for (int i = 0; i < NUM_SENDERS; i++) begin
      in_deq[i] = beat && (grant_q == ID_WIDTH'(i));
    end
  end

  always_comb begin
    state_d    = state_q;
    grant_d    = grant_q;
    beat_cnt_d = beat_cnt_q;
`ifndef STREAM_ARBITER_FIXED_PRIO_EN
    rr_ptr_d   = rr_ptr_q;
`endif
    case (state_q)
      IDLE: begin
        if (|in_empty_n) begin
          grant_d    = pick;
          beat_cnt_d = '0;
          state_d    = BURST;
        end
      end
      BURST: begin
        if (beat) begin
          beat_cnt_d = beat_cnt_q + 1'b1;
          if (last_beat) begin
            beat_cnt_d = '0;
            state_d    = IDLE;
`ifndef STREAM_ARBITER_FIXED_PRIO_EN
            rr_ptr_d   = grant_inc;
`endif
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      grant_q    <= '0;
      beat_cnt_q <= '0;
`ifndef STREAM_ARBITER_FIXED_PRIO_EN
      rr_ptr_q   <= '0;
`endif
    end else begin
      state_q    <= state_d;
      grant_q    <= grant_d;
      beat_cnt_q <= beat_cnt_d;
`ifndef STREAM_ARBITER_FIXED_PRIO_EN
      rr_ptr_q   <= rr_ptr_d;
`endif
    end
  end

endmodule
`default_nettype wire
